aoi_sweep_tester: RTL and testbench

- Sequential stimulus-and-check stage wrapped around the 4-input AND-OR-INVERT gate block.
- Upstream role: drives the gate's a, b, c, d inputs through all 16 combinations, one after another.
- Downstream role: consumes the gate's inverted output h and compares it against the expected value ~((a&b)|(c&d)).
- Reports progress, a done pulse and an error count, so the lab board can self-test the gate.

---
 rtl/aoi_sweep_tester.sv | 132 +++++++++++++
 tb/tb_aoi_sweep_tester.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/aoi_sweep_tester.sv
// Stimulus-and-check stage for a 4-input AND-OR-INVERT gate: sweeps all 16
// input vectors, samples the returned h on the last dwell cycle and counts mismatches.
module aoi_sweep_tester #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             abort,
    input  logic             h_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic [3:0]       vec_idx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
    localparam logic [CNT_W-1:0] ERR_MAX    = '1;

    logic [1:0]       state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [7:0]       dwell_q, dwell_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             flag_q, flag_d;
    logic             busy_q, done_q;
    logic             exp_h;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        dwell_d = dwell_q;
        err_d   = err_q;
        flag_d  = flag_q;
        exp_h   = ~((vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]));

        if (abort) begin
            state_d = S_IDLE;
            vec_d   = '0;
            dwell_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    vec_d   = '0;
                    dwell_d = '0;
                    if (start) begin
                        state_d = S_DRIVE;
                        err_d   = '0;
                        flag_d  = 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (dwell_q == DWELL_LAST) begin
                        if (h_in != exp_h) begin
                            flag_d = 1'b1;
                            if (err_q != ERR_MAX)
                                err_d = err_q + CNT_W'(1);
                        end
                        if (vec_q == 4'hF) begin
                            state_d = S_DONE;
                        end else if (step_mode) begin
                            state_d = S_WAIT;
                        end else begin
                            vec_d   = vec_q + 4'd1;
                            dwell_d = '0;
                        end
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
                S_WAIT: begin
                    // Dropping step_mode while parked acts as an implicit step.
                    if (step || !step_mode) begin
                        state_d = S_DRIVE;
                        vec_d   = vec_q + 4'd1;
                        dwell_d = '0;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    vec_d   = '0;
                    dwell_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    vec_d   = '0;
                    dwell_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            dwell_q <= '0;
            err_q   <= '0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
            flag_q  <= flag_d;
            busy_q  <= (state_d == S_DRIVE) || (state_d == S_WAIT);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign {a, b, c, d} = vec_q;
    assign vec_idx      = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_cnt      = err_q;
    assign err_flag     = flag_q;

endmodule

// File: tb/tb_aoi_sweep_tester.sv
// Bench for aoi_sweep_tester: a gate model with programmable faults feeds h_in,
// expectations come from vector-level timing and error-count arithmetic.
module tb_aoi_sweep_tester;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst_n, start, step_mode, step, abort, h_in;
    logic       a, b, c, d, busy, done, err_flag;
    logic [3:0] vec_idx;
    logic [4:0] err_cnt;
    logic       a_s, b_s, c_s, d_s, busy_s, done_s, err_flag_s;
    logic [3:0] vec_idx_s;
    logic [2:0] err_cnt_s;

    int         hmode;
    logic [15:0] fmask;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    aoi_sweep_tester #(.DWELL(DW), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
        .abort(abort), .h_in(h_in), .a(a), .b(b), .c(c), .d(d), .vec_idx(vec_idx),
        .busy(busy), .done(done), .err_cnt(err_cnt), .err_flag(err_flag)
    );

    // Narrow counter twin sharing the same h_in to exercise saturation.
    aoi_sweep_tester #(.DWELL(DW), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
        .abort(abort), .h_in(h_in), .a(a_s), .b(b_s), .c(c_s), .d(d_s), .vec_idx(vec_idx_s),
        .busy(busy_s), .done(done_s), .err_cnt(err_cnt_s), .err_flag(err_flag_s)
    );

    function automatic bit aoi_ref(int v);
        return !((((v >> 3) & 1) == 1 && ((v >> 2) & 1) == 1) ||
                 (((v >> 1) & 1) == 1 && (v & 1) == 1));
    endfunction

    function automatic bit gate_out(int hm, logic [15:0] m, int v);
        if (hm == 1) return 1'b0;
        if (hm == 2) return 1'b1;
        return aoi_ref(v) ^ m[v];
    endfunction

    function automatic int exp_errs(int hm, logic [15:0] m, int upto);
        int n = 0;
        for (int v = 0; v < upto; v++)
            if (gate_out(hm, m, v) != aoi_ref(v)) n++;
        return n;
    endfunction

    always_comb h_in = gate_out(hmode, fmask, int'({a, b, c, d}));

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_sweep(input int hm, input logic [15:0] m, input bit poke_start);
        int e;
        hmode = hm; fmask = m; step_mode = 1'b0;
        e = exp_errs(hm, m, 16);
        @(negedge clk) start = 1'b1;
        for (int k = 1; k <= 16 * DW + 2; k++) begin
            @(negedge clk);
            start = (poke_start && k == 20);
            if (k == 1) begin
                chk("clr_err", err_cnt, 0);
                chk("clr_flag", err_flag, 0);
            end
            if (k <= 16 * DW) begin
                chk("vec", vec_idx, (k - 1) / DW);
                chk("abcd", {a, b, c, d}, (k - 1) / DW);
                chk("busy", busy, 1);
                chk("done_lo", done, 0);
            end else if (k == 16 * DW + 1) begin
                chk("done_hi", done, 1);
                chk("done_s", done_s, 1);
                chk("done_vec", vec_idx, 15);
                chk("done_busy", busy, 0);
            end else begin
                chk("post_done", done, 0);
                chk("post_abcd", {a, b, c, d}, 0);
                chk("post_vec_s", vec_idx_s, 0);
            end
        end
        chk("err_cnt", err_cnt, e);
        chk("err_flag", err_flag, e > 0);
        chk("err_cnt_sat", err_cnt_s, e > 7 ? 7 : e);
        chk("err_flag_sat", err_flag_s, e > 0);
    endtask

    task automatic step_sweep();
        int w;
        hmode = 0; fmask = '0; step_mode = 1'b1;
        @(negedge clk) start = 1'b1;
        for (int k = 1; k <= DW; k++) begin
            @(negedge clk);
            start = 1'b0;
            step = (k == 2);
            chk("st_v0", vec_idx, 0);
            chk("st_busy0", busy, 1);
        end
        step = 1'b0;
        w = $urandom_range(6, 2);
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            chk("st_hold0", vec_idx, 0);
            chk("st_nodone0", done, 0);
        end
        for (int n = 1; n <= 15; n++) begin
            if (n == 8) step_mode = 1'b0; else step = 1'b1;
            @(negedge clk);
            step = 1'b0; step_mode = 1'b1;
            chk("st_adv", vec_idx, n);
            for (int j = 2; j <= DW; j++) begin
                @(negedge clk);
                chk("st_drive", vec_idx, n);
            end
            if (n < 15) begin
                w = $urandom_range(3, 1);
                for (int i = 0; i < w; i++) begin
                    @(negedge clk);
                    chk("st_wait", vec_idx, n);
                    chk("st_wbusy", busy, 1);
                    chk("st_wdone", done, 0);
                end
            end
        end
        @(negedge clk);
        chk("st_done", done, 1);
        chk("st_done_vec", vec_idx, 15);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("st_after", done, 0);
        chk("st_after_vec", vec_idx, 0);
        @(negedge clk);
        chk("st_extra_step", busy, 0);
        chk("st_err", err_cnt, 0);
        step_mode = 1'b0;
    endtask

    task automatic abort_test();
        bit found = 0;
        int ndone = 0;
        logic [15:0] m = 16'($urandom);
        hmode = 0; fmask = m; step_mode = 1'b0;
        @(negedge clk) start = 1'b1;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (vec_idx == 4'd5) found = 1;
        end
        chk("ab_reach", found, 1);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_vec", vec_idx, 0);
        chk("ab_abcd", {a, b, c, d}, 0);
        chk("ab_err", err_cnt, exp_errs(0, m, 5));
        chk("ab_flag", err_flag, exp_errs(0, m, 5) > 0);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ab_nodone", ndone, 0);
        start = 1'b1; abort = 1'b1;
        @(negedge clk) start = 1'b0; abort = 1'b0;
        chk("ab_start_abort", busy, 0);
        @(negedge clk);
        chk("ab_still_idle", busy, 0);
        run_sweep(0, m, 1'b0);
    endtask

    task automatic reset_test();
        bit found = 0;
        int nact = 0;
        hmode = 1; step_mode = 1'b0;
        @(negedge clk) start = 1'b1;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (vec_idx == 4'd9) found = 1;
        end
        chk("rs_reach", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_abcd", {a, b, c, d}, 0);
        chk("rs_vec", vec_idx, 0);
        chk("rs_busy", busy, 0);
        chk("rs_err", err_cnt, 0);
        chk("rs_flag", err_flag, 0);
        chk("rs_err_s", err_cnt_s, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) nact++;
        end
        chk("rs_idle", nact, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0;
        hmode = 0; fmask = '0;
        repeat (2) @(negedge clk);
        chk("rst_abcd", {a, b, c, d}, 0);
        chk("rst_vec", vec_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_flag", err_flag, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 16'h0000, 1'b0);
        run_sweep(1, 16'h0000, 1'b0);
        run_sweep(2, 16'h0000, 1'b1);
        run_sweep(0, 16'h8000, 1'b0);
        for (int i = 0; i < 4; i++) run_sweep(0, 16'($urandom), i[0]);
        step_sweep();
        abort_test();
        reset_test();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
